// File: rtl/vet_seq_mac_feed_if.sv
// Feeder bus: element-buffer writes, run control, MAC m/p stream.
// Master drives writes/start, slave returns status and the stream.
interface vet_seq_mac_feed_if #(
  parameter int W  = 10,
  parameter int AW = 3
);
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_m;
  logic [W-1:0]  wr_p;
  logic [AW:0]   len;
  logic          start;
  logic          busy;
  logic [W-1:0]  m;
  logic [W-1:0]  p;
  logic          done;

  modport master (
    output wr_en, wr_addr, wr_m, wr_p, len, start,
    input  busy, m, p, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_m, wr_p, len, start,
    output busy, m, p, done
  );
endinterface

// File: rtl/vet_seq_mac_feed.sv
// Buffers two element vectors and streams one m/p pair per clock
// into the MAC; drives zeros otherwise so the accumulator holds.
module vet_seq_mac_feed #(
  parameter int W     = 10,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input logic               CLOCK,
  input logic               RESET,
  vet_seq_mac_feed_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [AW:0] LIM = (AW+1)'(DEPTH);

  state_t        state_q, state_d;
  logic [AW:0]   idx_q, idx_d;
  logic [AW:0]   n_q, n_d;
  logic [W-1:0]  m_q, m_d;
  logic [W-1:0]  p_q, p_d;
  logic [W-1:0]  mbuf [DEPTH];
  logic [W-1:0]  pbuf [DEPTH];

  // Element buffers: writable only while idle, never cleared.
  always_ff @(posedge CLOCK) begin
    if (!RESET && bus.wr_en && state_q == IDLE) begin
      mbuf[bus.wr_addr] <= bus.wr_m;
      pbuf[bus.wr_addr] <= bus.wr_p;
    end
  end

  // State, index, length and the registered m/p outputs.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q <= IDLE;
      idx_q   <= '0;
      n_q     <= '0;
      m_q     <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
      m_q     <= m_d;
      p_q     <= p_d;
    end
  end

  // Next state; m/p default to zero so the MAC adds nothing.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    n_d     = n_q;
    m_d     = '0;
    p_d     = '0;
    unique case (state_q)
      IDLE: begin
        if (bus.start && bus.len != '0) begin
          state_d = STREAM;
          idx_d   = '0;
          n_d     = (bus.len > LIM) ? LIM : bus.len;
        end
      end
      STREAM: begin
        if (idx_q < n_q) begin
          m_d   = mbuf[idx_q[AW-1:0]];
          p_d   = pbuf[idx_q[AW-1:0]];
          idx_d = idx_q + 1'b1;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.m    = m_q;
  assign bus.p    = p_q;
  assign bus.busy = (state_q != IDLE);
  assign bus.done = (state_q == DONE);
endmodule
